// File: rtl/usb_serial_fifo.sv
// USB serial bridge: a register-mapped pair of byte FIFOs between a 32-bit bus
// and a serial device. TX bytes are written through TDR and streamed out on the
// send handshake. RX bytes arrive on the recv strobe and are popped by reading RDR.
// CTRL flushes either FIFO. STA reports the counts, the flags and the sticky overflows.
module usb_serial_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        write_i,
    input  logic        read_i,
    input  logic [3:0]  data_be_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic [7:0]  recv_data_i,
    input  logic        recv_valid_i,
    output logic [7:0]  send_data_o,
    output logic        send_valid_o,
    input  logic        send_ready_i,
    input  logic        connected_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_RDR  = 2'd1;
    localparam logic [1:0] ADDR_TDR  = 2'd2;
    localparam logic [1:0] ADDR_STA  = 2'd3;

    // Storage is never reset. Outputs mask it with the count so stale bytes never leak out.
    logic [7:0]    r_tx_mem [DEPTH];
    logic [7:0]    r_rx_mem [DEPTH];
    logic [PW-1:0] r_tx_wr_ptr;
    logic [PW-1:0] r_tx_rd_ptr;
    logic [PW-1:0] r_rx_wr_ptr;
    logic [PW-1:0] r_rx_rd_ptr;
    logic [CW-1:0] r_tx_count;
    logic [CW-1:0] r_rx_count;
    logic          r_tx_ovf;
    logic          r_rx_ovf;

    logic          w_ctrl_wr;
    logic          w_sta_wr;
    logic          w_tx_flush;
    logic          w_rx_flush;
    logic          w_tx_push_req;
    logic          w_rx_push_req;
    logic          w_tx_full;
    logic          w_rx_full;
    logic          w_tx_empty;
    logic          w_rx_nonempty;
    logic          w_tx_push;
    logic          w_rx_push;
    logic          w_tx_pop;
    logic          w_rx_pop;
    logic [7:0]    w_tx_head;
    logic [7:0]    w_rx_head;
    logic [7:0]    w_tx_count8;
    logic [7:0]    w_rx_count8;
    logic [31:0]   w_sta;
    logic          w_unused_bits;

    assign w_ctrl_wr     = write_i & (addr_i[3:2] == ADDR_CTRL);
    assign w_sta_wr      = write_i & (addr_i[3:2] == ADDR_STA);
    assign w_tx_flush    = w_ctrl_wr & wdata_i[0];
    assign w_rx_flush    = w_ctrl_wr & wdata_i[1];

    assign w_tx_full     = (r_tx_count == FULL_COUNT);
    assign w_rx_full     = (r_rx_count == FULL_COUNT);
    assign w_tx_empty    = (r_tx_count == '0);
    assign w_rx_nonempty = (r_rx_count != '0);

    // Fullness is judged on the current count: a same-cycle pop never makes room.
    assign w_tx_push_req = write_i & (addr_i[3:2] == ADDR_TDR) & data_be_i[0];
    assign w_rx_push_req = recv_valid_i;
    assign w_tx_push     = w_tx_push_req & ~w_tx_full & ~w_tx_flush;
    assign w_rx_push     = w_rx_push_req & ~w_rx_full & ~w_rx_flush;
    assign w_tx_pop      = send_valid_o & send_ready_i & ~w_tx_flush;
    assign w_rx_pop      = read_i & (addr_i[3:2] == ADDR_RDR) & w_rx_nonempty & ~w_rx_flush;

    assign w_tx_head     = w_tx_empty    ? 8'h00 : r_tx_mem[r_tx_rd_ptr];
    assign w_rx_head     = w_rx_nonempty ? r_rx_mem[r_rx_rd_ptr] : 8'h00;

    assign send_valid_o  = ~w_tx_empty & connected_i;
    assign send_data_o   = w_tx_head;

    assign w_tx_count8   = 8'(r_tx_count);
    assign w_rx_count8   = 8'(r_rx_count);
    assign w_sta         = {8'h00, w_tx_count8, w_rx_count8, 2'b00, r_tx_ovf, r_rx_ovf,
                            w_tx_empty, w_tx_full, w_rx_nonempty, connected_i};

    // These bus bits carry no meaning for this register map.
    assign w_unused_bits = ^{addr_i[1:0], data_be_i[3:1], wdata_i[31:8]};

    // TX storage write: only accepted pushes land in the array.
    always_ff @(posedge clk_i) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr_ptr] <= wdata_i[7:0];
        end
    end

    // RX storage write: only accepted pushes land in the array.
    always_ff @(posedge clk_i) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr_ptr] <= recv_data_i;
        end
    end

    // TX pointers and count. A flush overrides any push or pop in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_count  <= '0;
        end else if (w_tx_flush) begin
            r_tx_wr_ptr <= '0;
            r_tx_rd_ptr <= '0;
            r_tx_count  <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wr_ptr <= r_tx_wr_ptr + PW'(1);
            end
            if (w_tx_pop) begin
                r_tx_rd_ptr <= r_tx_rd_ptr + PW'(1);
            end
            if (w_tx_push & ~w_tx_pop) begin
                r_tx_count <= r_tx_count + CW'(1);
            end else if (~w_tx_push & w_tx_pop) begin
                r_tx_count <= r_tx_count - CW'(1);
            end
        end
    end

    // RX pointers and count. A flush overrides any push or pop in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_count  <= '0;
        end else if (w_rx_flush) begin
            r_rx_wr_ptr <= '0;
            r_rx_rd_ptr <= '0;
            r_rx_count  <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wr_ptr <= r_rx_wr_ptr + PW'(1);
            end
            if (w_rx_pop) begin
                r_rx_rd_ptr <= r_rx_rd_ptr + PW'(1);
            end
            if (w_rx_push & ~w_rx_pop) begin
                r_rx_count <= r_rx_count + CW'(1);
            end else if (~w_rx_push & w_rx_pop) begin
                r_rx_count <= r_rx_count - CW'(1);
            end
        end
    end

    // Sticky overflow flags. A push attempt against a full FIFO wins over a clear in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
        end else begin
            if (w_tx_push_req & w_tx_full) begin
                r_tx_ovf <= 1'b1;
            end else if (w_sta_wr & wdata_i[5]) begin
                r_tx_ovf <= 1'b0;
            end
            if (w_rx_push_req & w_rx_full) begin
                r_rx_ovf <= 1'b1;
            end else if (w_sta_wr & wdata_i[4]) begin
                r_rx_ovf <= 1'b0;
            end
        end
    end

    // Read mux: purely combinational from the address, independent of read_i.
    always_comb begin
        rdata_o = 32'h0;
        case (addr_i[3:2])
            ADDR_RDR: rdata_o = {24'h0, w_rx_head};
            ADDR_STA: rdata_o = w_sta;
            default:  rdata_o = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_usb_serial_fifo.sv
// Bench for usb_serial_fifo. Directed scenarios are followed by a randomized phase.
// Every cycle, the outputs are compared with a queue-based reference model.
module tb_usb_serial_fifo;

    localparam int DEPTH = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        write_i = 1'b0;
    logic        read_i = 1'b0;
    logic [3:0]  data_be_i = 4'h0;
    logic [3:0]  addr_i = 4'hC;
    logic [31:0] wdata_i = 32'h0;
    logic [31:0] rdata_o;
    logic [7:0]  recv_data_i = 8'h0;
    logic        recv_valid_i = 1'b0;
    logic [7:0]  send_data_o;
    logic        send_valid_o;
    logic        send_ready_i = 1'b0;
    logic        connected_i = 1'b0;

    usb_serial_fifo #(.DEPTH(DEPTH)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .write_i      (write_i),
        .read_i       (read_i),
        .data_be_i    (data_be_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .recv_data_i  (recv_data_i),
        .recv_valid_i (recv_valid_i),
        .send_data_o  (send_data_o),
        .send_valid_o (send_valid_o),
        .send_ready_i (send_ready_i),
        .connected_i  (connected_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain queues plus the two sticky flags.
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         m_tx_ovf = 1'b0;
    bit         m_rx_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
            $error("comparison %s differs", tag);
        end
    endtask

    function automatic logic [31:0] model_sta();
        logic [7:0] tc;
        logic [7:0] rc;
        tc = 8'(tx_q.size());
        rc = 8'(rx_q.size());
        return {8'h00, tc, rc, 2'b00, m_tx_ovf, m_rx_ovf,
                (tx_q.size() == 0), (tx_q.size() == DEPTH), (rx_q.size() != 0), connected_i};
    endfunction

    function automatic logic [31:0] model_rdata();
        if (addr_i[3:2] == 2'd1) return (rx_q.size() != 0) ? {24'h0, rx_q[0]} : 32'h0;
        if (addr_i[3:2] == 2'd3) return model_sta();
        return 32'h0;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_apply();
        bit flush_tx;
        bit flush_rx;
        bit sta_wr;
        bit tx_req;
        bit tx_full;
        bit rx_full;
        bit tx_pop;
        bit rx_pop;
        flush_tx = write_i && addr_i[3:2] == 2'd0 && wdata_i[0];
        flush_rx = write_i && addr_i[3:2] == 2'd0 && wdata_i[1];
        sta_wr   = write_i && addr_i[3:2] == 2'd3;
        tx_req   = write_i && addr_i[3:2] == 2'd2 && data_be_i[0];
        tx_full  = (tx_q.size() == DEPTH);
        rx_full  = (rx_q.size() == DEPTH);
        tx_pop   = (tx_q.size() != 0) && connected_i && send_ready_i;
        rx_pop   = read_i && addr_i[3:2] == 2'd1 && (rx_q.size() != 0);
        if (tx_req && tx_full) m_tx_ovf = 1'b1;
        else if (sta_wr && wdata_i[5]) m_tx_ovf = 1'b0;
        if (recv_valid_i && rx_full) m_rx_ovf = 1'b1;
        else if (sta_wr && wdata_i[4]) m_rx_ovf = 1'b0;
        if (flush_tx) tx_q.delete();
        else begin
            if (tx_pop) void'(tx_q.pop_front());
            if (tx_req && !tx_full) tx_q.push_back(wdata_i[7:0]);
        end
        if (flush_rx) rx_q.delete();
        else begin
            if (rx_pop) void'(rx_q.pop_front());
            if (recv_valid_i && !rx_full) rx_q.push_back(recv_data_i);
        end
    endtask

    // One clock: compare outputs with the model, update the model, take the edge, and return strobes to idle.
    task automatic tick(input string tag);
        logic sv_exp;
        logic [7:0] sd_exp;
        #1;
        sv_exp = (tx_q.size() != 0) && connected_i;
        sd_exp = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
        check({tag, " rdata"}, rdata_o, model_rdata());
        check({tag, " send_valid"}, 32'(send_valid_o), 32'(sv_exp));
        check({tag, " send_data"}, 32'(send_data_o), 32'(sd_exp));
        model_apply();
        @(posedge clk_i);
        #1;
        write_i = 1'b0;
        read_i = 1'b0;
        recv_valid_i = 1'b0;
        data_be_i = 4'h0;
        wdata_i = 32'h0;
        addr_i = 4'hC;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
        write_i = 1'b1;
        addr_i = a;
        wdata_i = d;
        data_be_i = be;
    endtask

    task automatic rd(input logic [3:0] a);
        read_i = 1'b1;
        addr_i = a;
    endtask

    task automatic rv(input logic [7:0] d);
        recv_valid_i = 1'b1;
        recv_data_i = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("reset sta", rdata_o, 32'h0000_0008);
        check("reset send_valid", 32'(send_valid_o), 32'h0);
        check("reset send_data", 32'(send_data_o), 32'h0);
        rst_i = 1'b0;

        // TX basic streaming
        connected_i = 1'b1;
        send_ready_i = 1'b0;
        wr(4'h8, 32'h41); tick("tdr");
        wr(4'h8, 32'h42); tick("tdr");
        #1;
        check("tx2 send_valid", 32'(send_valid_o), 32'h1);
        check("tx2 send_data", 32'(send_data_o), 32'h41);
        check("tx2 count", 32'(rdata_o[23:16]), 32'h2);
        send_ready_i = 1'b1;
        tick("pop1");
        #1;
        check("tx pop1 data", 32'(send_data_o), 32'h42);
        tick("pop2");
        #1;
        check("tx drained valid", 32'(send_valid_o), 32'h0);
        send_ready_i = 1'b0;

        // RX basic, including a read of an empty RX FIFO
        rv(8'h10); tick("rx");
        rv(8'h20); tick("rx");
        rv(8'h30); tick("rx");
        #1;
        check("rx3 nonempty", 32'(rdata_o[1]), 32'h1);
        check("rx3 count", 32'(rdata_o[15:8]), 32'h3);
        for (int i = 0; i < 3; i++) begin
            rd(4'h4);
            #1;
            check("rdr data", rdata_o, 32'h10 * (i + 1));
            tick("rdr");
        end
        rd(4'h4);
        #1;
        check("rdr empty", rdata_o, 32'h0);
        tick("rdr empty");
        #1;
        check("rdr empty counts", 32'(rdata_o[23:8]), 32'h0);

        // TX overflow at DEPTH, then clear the sticky flag
        for (int i = 0; i < DEPTH + 1; i++) begin
            wr(4'h8, 32'hA0 + i);
            tick("fill tx");
        end
        #1;
        check("tx full", 32'(rdata_o[2]), 32'h1);
        check("tx ovf", 32'(rdata_o[5]), 32'h1);
        check("tx count full", 32'(rdata_o[23:16]), DEPTH);
        wr(4'hC, 32'h20); tick("sta clr");
        #1;
        check("tx ovf cleared", 32'(rdata_o[5]), 32'h0);
        send_ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            check("tx drain order", 32'(send_data_o), 32'hA0 + i);
            tick("drain");
        end
        #1;
        check("17th absent", 32'(send_valid_o), 32'h0);
        send_ready_i = 1'b0;

        // RX with 15 entries: simultaneous push and pop across pointer wrap
        for (int i = 0; i < 15; i++) begin
            rv(8'h50 + 8'(i));
            tick("rx15");
        end
        for (int i = 0; i < 6; i++) begin
            rv(8'h70 + 8'(i));
            rd(4'h4);
            #1;
            check("rx wrap data", rdata_o, 32'h50 + i);
            tick("rx wrap");
            #1;
            check("rx wrap count", 32'(rdata_o[15:8]), 32'd15);
        end
        for (int i = 0; i < 15; i++) begin
            rd(4'h4);
            tick("rx drain");
        end

        // TX disconnected, then flushed while a pop would otherwise happen
        connected_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr(4'h8, 32'hC0 + i);
            tick("tx5");
        end
        #1;
        check("disc send_valid", 32'(send_valid_o), 32'h0);
        check("disc count", 32'(rdata_o[23:16]), 32'd5);
        connected_i = 1'b1;
        send_ready_i = 1'b1;
        wr(4'h0, 32'h1); tick("tx flush");
        #1;
        check("flush tx count", 32'(rdata_o[23:16]), 32'h0);
        check("flush tx empty", 32'(rdata_o[3]), 32'h1);
        send_ready_i = 1'b0;

        // RX flush beats a same-cycle push
        rv(8'h01); tick("rx pre");
        rv(8'h02); wr(4'h0, 32'h2); tick("rx flush");
        #1;
        check("flush rx count", 32'(rdata_o[15:8]), 32'h0);

        // RX overflow wins over a same-cycle clear
        for (int i = 0; i < DEPTH + 1; i++) begin
            rv(8'(i));
            tick("fill rx");
        end
        rv(8'hEE); wr(4'hC, 32'h10); tick("ovf vs clr");
        #1;
        check("rx ovf kept", 32'(rdata_o[4]), 32'h1);
        wr(4'hC, 32'h10); tick("rx clr");
        #1;
        check("rx ovf cleared", 32'(rdata_o[4]), 32'h0);
        wr(4'h0, 32'h3); tick("flush both");

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            int op;
            op = $urandom_range(0, 9);
            connected_i = ($urandom_range(0, 7) != 0);
            send_ready_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) rv(8'($urandom));
            case (op)
                0, 1, 2, 3: wr(4'h8, $urandom, 4'($urandom));
                4, 5:       rd(4'h4);
                6:          wr(4'h0, ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 3)) : 32'h0);
                7:          wr(4'hC, $urandom);
                8:          begin read_i = 1'b1; addr_i = 4'($urandom); end
                default:    addr_i = 4'($urandom);
            endcase
            tick("rand");
        end

        // Asynchronous reset with both FIFOs holding data
        connected_i = 1'b1;
        send_ready_i = 1'b0;
        wr(4'h8, 32'h77); rv(8'h88); tick("pre reset");
        wr(4'h8, 32'h78); rv(8'h89); tick("pre reset");
        #2;
        rst_i = 1'b1;
        #1;
        check("async rst send_valid", 32'(send_valid_o), 32'h0);
        check("async rst send_data", 32'(send_data_o), 32'h0);
        check("async rst sta", rdata_o, 32'h0000_0009);
        addr_i = 4'h4;
        #0.5;
        check("async rst rdr", rdata_o, 32'h0);
        tx_q.delete();
        rx_q.delete();
        m_tx_ovf = 1'b0;
        m_rx_ovf = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        addr_i = 4'hC;
        tick("post reset");
        tick("post reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
